// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: opcode/condition encodings,
// default widths and operand-packet field positions.
package execute_stage_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned RW_DEF = 3;

    typedef enum logic [3:0] {
        OP_ADI  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_NAND = 4'b0010
    } opcode_e;

    typedef enum logic [1:0] {
        CZ_ALWAYS  = 2'b00,
        CZ_IF_Z    = 2'b01,
        CZ_IF_C    = 2'b10,
        CZ_ILLEGAL = 2'b11
    } cz_e;

    // Packet layout from LSB: cz, dest, opB, opA, opcode.
    localparam int unsigned CZ_LSB   = 0;
    localparam int unsigned DEST_LSB = 2;

    function automatic int unsigned pkt_width(input int unsigned dw, input int unsigned rw);
        return 2 * dw + rw + 6;
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADI) || (op == OP_ADD) || (op == OP_NAND);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Operand-packet input and writeback-packet output of the execute stage.
interface execute_stage_if
    import execute_stage_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
);
    localparam int unsigned PW = 2 * DW + RW + 6;

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pkt;
    logic          out_valid;
    logic          out_ready;
    logic          out_wr_en;
    logic [RW-1:0] out_dest;
    logic [DW-1:0] out_result;
    logic          out_illegal;
    logic          carry_flag;
    logic          zero_flag;

    modport master (
        output in_valid, in_pkt, out_ready,
        input  in_ready, out_valid, out_wr_en, out_dest, out_result,
               out_illegal, carry_flag, zero_flag
    );

    modport slave (
        input  in_valid, in_pkt, out_ready,
        output in_ready, out_valid, out_wr_en, out_dest, out_result,
               out_illegal, carry_flag, zero_flag
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage: add (ADI/ADD family) and NAND.
module exec_alu
    import execute_stage_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic [DW-1:0] result,
    output logic          carry_out,
    output logic          zero_out
);

    logic [DW:0] sum;

    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        result    = '0;
        carry_out = 1'b0;
        case (opcode)
            OP_ADI, OP_ADD: begin
                result    = sum[DW-1:0];
                carry_out = sum[DW];
            end
            OP_NAND: result = ~(op_a & op_b);
            default: ;
        endcase
        zero_out = (result == '0);
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU, conditional execution against the owned C/Z flags,
// and a single registered writeback slot with valid/ready and flush.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    execute_stage_if.slave  bus
);

    localparam int unsigned PW = 2 * DW + RW + 6;

    logic [3:0]    opcode;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [RW-1:0] dest;
    logic [1:0]    cz;

    assign opcode = bus.in_pkt[PW-1 -: 4];
    assign op_a   = bus.in_pkt[2*DW+RW+1 -: DW];
    assign op_b   = bus.in_pkt[DW+RW+1 -: DW];
    assign dest   = bus.in_pkt[DEST_LSB +: RW];
    assign cz     = bus.in_pkt[CZ_LSB +: 2];

    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          alu_zero;

    exec_alu #(.DW(DW)) u_alu (
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .result    (alu_result),
        .carry_out (alu_carry),
        .zero_out  (alu_zero)
    );

    logic          out_valid_q, out_valid_d;
    logic          out_wr_en_q, out_wr_en_d;
    logic [RW-1:0] out_dest_q, out_dest_d;
    logic [DW-1:0] out_result_q, out_result_d;
    logic          out_illegal_q, out_illegal_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;

    logic in_ready;
    logic accept;
    logic illegal;
    logic cond_ok;
    logic execute;

    assign in_ready = !flush && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    // ADI ignores cz, so cz=11 is only illegal for the conditional families.
    always_comb begin
        illegal = !is_legal_op(opcode) || ((opcode != OP_ADI) && (cz == CZ_ILLEGAL));
        cond_ok = 1'b1;
        if (opcode != OP_ADI) begin
            case (cz)
                CZ_IF_C: cond_ok = carry_q;
                CZ_IF_Z: cond_ok = zero_q;
                default: cond_ok = 1'b1;
            endcase
        end
        execute = !illegal && cond_ok;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_wr_en_d   = out_wr_en_q;
        out_dest_d    = out_dest_q;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_wr_en_d   = execute;
            out_dest_d    = dest;
            out_result_d  = execute ? alu_result : '0;
            out_illegal_d = illegal;
            if (execute) begin
                zero_d = alu_zero;
                if (opcode != OP_NAND) carry_d = alu_carry;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_wr_en_q   <= 1'b0;
            out_dest_q    <= '0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_wr_en_q   <= out_wr_en_d;
            out_dest_q    <= out_dest_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_wr_en   = out_wr_en_q;
    assign bus.out_dest    = out_dest_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_illegal = out_illegal_q;
    assign bus.carry_flag  = carry_q;
    assign bus.zero_flag   = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;
    import execute_stage_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   tests = 0;
    int   fails = 0;

    execute_stage_if #(.DW(16), .RW(3)) bus ();

    execute_stage #(.DW(16), .RW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] pkt(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [2:0] d,
                                        input logic [1:0] cz);
        return {op, a, b, d, cz};
    endfunction

    // {valid, wr_en, illegal, dest, result, C, Z}
    function automatic logic [23:0] obs();
        return {bus.out_valid, bus.out_wr_en, bus.out_illegal, bus.out_dest,
                bus.out_result, bus.carry_flag, bus.zero_flag};
    endfunction

    function automatic logic [23:0] ev(input logic v, input logic w, input logic il,
                                       input logic [2:0] d, input logic [15:0] r,
                                       input logic c, input logic z);
        return {v, w, il, d, r, c, z};
    endfunction

    task automatic drive(input logic [40:0] p);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_pkt   = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] e;
        bus.in_valid  = 1'b0;
        bus.in_pkt    = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        e = '0;
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL reset_outputs got %h exp %h", obs(), e); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [23:0] e;
        bus.out_ready = 1'b1;
        drive(pkt(OP_ADD, 16'h0003, 16'h0004, 3'd5, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd5, 16'h0007, 0, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL add_basic got %h exp %h", obs(), e); end
        idle();
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e;
        drive(pkt(OP_ADD, 16'hFFFF, 16'h0001, 3'd1, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd1, 16'h0000, 1, 1);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL wrap_add got %h exp %h", obs(), e); end
        drive(pkt(OP_ADD, 16'h0010, 16'h0020, 3'd2, CZ_IF_C));
        e = ev(1, 1, 0, 3'd2, 16'h0030, 0, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL adc_dependent got %h exp %h", obs(), e); end
        idle();
    endtask

    task automatic test_nand();
        logic [23:0] e;
        drive(pkt(OP_ADD, 16'hFFFF, 16'h0001, 3'd1, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd1, 16'h0000, 1, 1);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL nand_setup got %h exp %h", obs(), e); end
        drive(pkt(OP_NAND, 16'hFFFF, 16'hFFFF, 3'd3, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd3, 16'h0000, 1, 1);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL nand_zero got %h exp %h", obs(), e); end
        drive(pkt(OP_NAND, 16'h00F0, 16'h0F00, 3'd4, CZ_IF_Z));
        e = ev(1, 1, 0, 3'd4, 16'hFFFF, 1, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL ndz_dependent got %h exp %h", obs(), e); end
        idle();
    endtask

    task automatic test_cond_illegal();
        logic [23:0] e;
        logic [4:0]  f;
        // C=1, Z=0 here
        drive(pkt(OP_ADD, 16'h0001, 16'h0002, 3'd4, CZ_IF_Z));
        e = ev(1, 0, 0, 3'd4, 16'h0000, 1, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL adz_skipped got %h exp %h", obs(), e); end
        drive(pkt(4'b0111, 16'h1234, 16'h4321, 3'd5, CZ_ALWAYS));
        f = {bus.out_valid, bus.out_wr_en, bus.out_illegal, bus.carry_flag, bus.zero_flag};
        tests++;
        if (f !== 5'b10110) begin fails++; $display("FAIL illegal_opcode got %b exp 10110", f); end
        drive(pkt(OP_ADD, 16'h0001, 16'h0001, 3'd6, CZ_ILLEGAL));
        f = {bus.out_valid, bus.out_wr_en, bus.out_illegal, bus.carry_flag, bus.zero_flag};
        tests++;
        if (f !== 5'b10110) begin fails++; $display("FAIL illegal_cz got %b exp 10110", f); end
        drive(pkt(OP_NAND, 16'hFF00, 16'h0F0F, 3'd7, CZ_IF_C));
        e = ev(1, 1, 0, 3'd7, 16'hF0FF, 1, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL ndc_taken got %h exp %h", obs(), e); end
        idle();
    endtask

    task automatic test_stall();
        logic [23:0] e;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(pkt(OP_ADI, 16'h0005, 16'h0003, 3'd6, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd6, 16'h0008, 0, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL adi_accept got %h exp %h", obs(), e); end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_pkt   = pkt(OP_ADD, 16'h0100, 16'h0200, 3'd7, CZ_ALWAYS);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
            tests++;
            if (obs() !== e) begin fails++; $display("FAIL stall_hold[%0d] got %h exp %h", i, obs(), e); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
        @(posedge clk); #1;
        e = ev(1, 1, 0, 3'd7, 16'h0300, 0, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL release_next got %h exp %h", obs(), e); end
        idle();
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL release_no_dup got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        logic [23:0] e;
        logic [2:0]  f;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(pkt(OP_ADD, 16'h0001, 16'h0001, 3'd1, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd1, 16'h0002, 0, 0);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL flush_setup got %h exp %h", obs(), e); end
        @(negedge clk);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_pkt    = pkt(OP_ADD, 16'hFFFF, 16'hFFFF, 3'd2, CZ_ALWAYS);
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
        @(posedge clk); #1;
        f = {bus.out_valid, bus.carry_flag, bus.zero_flag};
        tests++;
        if (f !== 3'b000) begin fails++; $display("FAIL flush_kill got %b exp 000", f); end
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        logic [23:0] e;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(pkt(OP_ADD, 16'hFFFF, 16'h0001, 3'd3, CZ_ALWAYS));
        e = ev(1, 1, 0, 3'd3, 16'h0000, 1, 1);
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL rst_setup got %h exp %h", obs(), e); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        e = '0;
        tests++;
        if (obs() !== e) begin fails++; $display("FAIL rst_async got %h exp %h", obs(), e); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_discard got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_nand();
        test_cond_illegal();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
